// File: rtl/nav_bit_sync_if.sv
// Stream/result bundle between the Costas loop front end, the bit
// synchroniser and the subframe stage.
interface nav_bit_sync_if #(
  parameter int MS_PER_BIT = 20
);
  localparam int PW = $clog2(MS_PER_BIT);

  logic          sample_en;
  logic          data_in;
  logic          clear;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_lock;
  logic [PW-1:0] lock_phase;

  modport master (
    output sample_en, data_in, clear,
    input  bit_out, bit_valid, bit_lock, lock_phase
  );

  modport slave (
    input  sample_en, data_in, clear,
    output bit_out, bit_valid, bit_lock, lock_phase
  );
endinterface

// File: rtl/nav_bit_sync.sv
// GPS nav bit synchroniser: 1 ms majority-vote symbols, transition histogram
// for 20 ms bit-edge search, then integrate-and-dump bit decisions.
module nav_bit_sync #(
  parameter int SAMPLES_PER_MS = 10,
  parameter int MS_PER_BIT     = 20,
  parameter int LOCK_THRESH    = 8,
  parameter int LOSS_MARGIN    = 10,
  parameter int LOSS_BITS      = 4
) (
  input  logic         CLK,
  input  logic         RST_n,
  nav_bit_sync_if.slave bus
);
  localparam int SW = $clog2(SAMPLES_PER_MS + 1);
  localparam int PW = $clog2(MS_PER_BIT);
  localparam int HW = $clog2(LOCK_THRESH + 1);
  localparam int AW = $clog2(MS_PER_BIT) + 2;
  localparam int WW = $clog2(LOSS_BITS + 1);

  typedef enum logic {SEARCH, LOCKED} state_e;

  // symbol stage
  logic [SW-1:0] samp_cnt_q, samp_cnt_d, ones_q, ones_d;
  logic [SW:0]   ones_tot;
  logic          sym_q, sym_d, sym_valid_q, sym_valid_d;

  // bit stage
  state_e               state_q, state_d;
  logic [PW-1:0]        ms_phase_q, ms_phase_d, last_tag;
  logic                 prev_sym_q, prev_sym_d, prev_vld_q, prev_vld_d;
  logic [HW-1:0]        hist_q [MS_PER_BIT];
  logic [HW-1:0]        hist_d [MS_PER_BIT];
  logic [HW-1:0]        hinc;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [AW-1:0]        mag;
  logic [WW-1:0]        weak_q, weak_d, weak_inc;
  logic                 started_q, started_d, in_bit;
  logic                 bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic                 bit_lock_q, bit_lock_d;
  logic [PW-1:0]        lock_phase_q, lock_phase_d;

  always_comb begin : p_symbol
    samp_cnt_d  = samp_cnt_q;
    ones_d      = ones_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    ones_tot    = {1'b0, ones_q} + {{SW{1'b0}}, bus.data_in};
    if (bus.sample_en) begin
      if (samp_cnt_q == SW'(SAMPLES_PER_MS - 1)) begin
        samp_cnt_d  = '0;
        ones_d      = '0;
        sym_valid_d = 1'b1;
        // 2*ones vs. period length; an exact tie keeps the previous symbol
        if ({ones_tot, 1'b0} > (SW+2)'(SAMPLES_PER_MS))      sym_d = 1'b1;
        else if ({ones_tot, 1'b0} < (SW+2)'(SAMPLES_PER_MS)) sym_d = 1'b0;
      end else begin
        samp_cnt_d = samp_cnt_q + SW'(1);
        ones_d     = ones_tot[SW-1:0];
      end
    end
    if (bus.clear) begin
      samp_cnt_d  = '0;
      ones_d      = '0;
      sym_d       = 1'b0;
      sym_valid_d = 1'b0;
    end
  end

  always_comb begin : p_fsm
    state_d      = state_q;
    ms_phase_d   = ms_phase_q;
    prev_sym_d   = prev_sym_q;
    prev_vld_d   = prev_vld_q;
    hist_d       = hist_q;
    acc_d        = acc_q;
    weak_d       = weak_q;
    started_d    = started_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    bit_lock_d   = bit_lock_q;
    lock_phase_d = lock_phase_q;
    hinc         = '0;
    sum          = '0;
    mag          = '0;
    weak_inc     = '0;
    in_bit       = 1'b0;
    last_tag     = (lock_phase_q == '0) ? PW'(MS_PER_BIT - 1) : lock_phase_q - PW'(1);

    if (sym_valid_q) begin
      ms_phase_d = (ms_phase_q == PW'(MS_PER_BIT - 1)) ? '0 : ms_phase_q + PW'(1);
      prev_sym_d = sym_q;
      prev_vld_d = 1'b1;
      case (state_q)
        SEARCH: begin
          if (prev_vld_q && (sym_q != prev_sym_q)) begin
            hinc               = hist_q[ms_phase_q] + HW'(1);
            hist_d[ms_phase_q] = hinc;
            if (hinc == HW'(LOCK_THRESH)) begin
              state_d      = LOCKED;
              bit_lock_d   = 1'b1;
              lock_phase_d = ms_phase_q;
              acc_d        = '0;
              weak_d       = '0;
              started_d    = 1'b0;
            end
          end
        end
        LOCKED: begin
          // symbols before the first bit edge after lock belong to a partial bit
          in_bit = started_q || (ms_phase_q == lock_phase_q);
          if (in_bit) begin
            started_d = 1'b1;
            sum       = sym_q ? acc_q + AW'(1) : acc_q - AW'(1);
            mag       = sum[AW-1] ? -sum : sum;
            if (ms_phase_q == last_tag) begin
              bit_valid_d = 1'b1;
              bit_out_d   = (sum == '0) ? sym_q : ~sum[AW-1];
              acc_d       = '0;
              if (mag < AW'(LOSS_MARGIN)) begin
                weak_inc = weak_q + WW'(1);
                weak_d   = weak_inc;
                if (weak_inc == WW'(LOSS_BITS)) begin
                  state_d      = SEARCH;
                  bit_lock_d   = 1'b0;
                  lock_phase_d = '0;
                  weak_d       = '0;
                  started_d    = 1'b0;
                  for (int i = 0; i < MS_PER_BIT; i++) hist_d[i] = '0;
                end
              end else begin
                weak_d = '0;
              end
            end else begin
              acc_d = sum;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (bus.clear) begin
      state_d      = SEARCH;
      ms_phase_d   = '0;
      prev_sym_d   = 1'b0;
      prev_vld_d   = 1'b0;
      acc_d        = '0;
      weak_d       = '0;
      started_d    = 1'b0;
      bit_out_d    = 1'b0;
      bit_valid_d  = 1'b0;
      bit_lock_d   = 1'b0;
      lock_phase_d = '0;
      for (int i = 0; i < MS_PER_BIT; i++) hist_d[i] = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      samp_cnt_q   <= '0;
      ones_q       <= '0;
      sym_q        <= 1'b0;
      sym_valid_q  <= 1'b0;
      state_q      <= SEARCH;
      ms_phase_q   <= '0;
      prev_sym_q   <= 1'b0;
      prev_vld_q   <= 1'b0;
      acc_q        <= '0;
      weak_q       <= '0;
      started_q    <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_lock_q   <= 1'b0;
      lock_phase_q <= '0;
      for (int i = 0; i < MS_PER_BIT; i++) hist_q[i] <= '0;
    end else begin
      samp_cnt_q   <= samp_cnt_d;
      ones_q       <= ones_d;
      sym_q        <= sym_d;
      sym_valid_q  <= sym_valid_d;
      state_q      <= state_d;
      ms_phase_q   <= ms_phase_d;
      prev_sym_q   <= prev_sym_d;
      prev_vld_q   <= prev_vld_d;
      acc_q        <= acc_d;
      weak_q       <= weak_d;
      started_q    <= started_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      bit_lock_q   <= bit_lock_d;
      lock_phase_q <= lock_phase_d;
      hist_q       <= hist_d;
    end
  end

  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.bit_lock   = bit_lock_q;
  assign bus.lock_phase = lock_phase_q;
endmodule

// File: tb/tb_nav_bit_sync.sv
// Directed bench for nav_bit_sync: symbol voting, edge search, bit decode,
// loss of lock and clear/reset behaviour.
module tb_nav_bit_sync;
  localparam int SPM = 10;
  localparam int MPB = 20;

  logic CLK   = 1'b0;
  logic RST_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   vcnt   = 0;

  nav_bit_sync_if #(.MS_PER_BIT(MPB)) bus ();

  nav_bit_sync dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (bus.bit_valid === 1'b1) vcnt <= vcnt + 1;

  // one symbol of back-to-back samples, n_ones leading ones; returns at T+1
  task automatic send_sym(input int n_ones);
    for (int i = 0; i < SPM; i++) begin
      @(negedge CLK);
      bus.sample_en = 1'b1;
      bus.data_in   = (i < n_ones);
    end
    @(negedge CLK);
    bus.sample_en = 1'b0;
    bus.data_in   = 1'b0;
  endtask

  task automatic send_syms(input int n, input int n_ones);
    for (int i = 0; i < n; i++) send_sym(n_ones);
  endtask

  task automatic do_reset();
    bus.sample_en = 1'b0;
    bus.data_in   = 1'b0;
    bus.clear     = 1'b0;
    RST_n         = 1'b0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
  endtask

  // last symbol of a bit, then bit_valid timing and value at T+1/T+2/T+3
  task automatic finish_bit(input int last_ones, input logic exp_bit, input string name);
    send_sym(last_ones);
    checks++;
    if (bus.bit_valid !== 1'b0) begin
      errors++; $display("FAIL %s T+1: bit_valid=%b required 0", name, bus.bit_valid);
    end
    @(negedge CLK);
    checks++;
    if (bus.bit_valid !== 1'b1 || bus.bit_out !== exp_bit) begin
      errors++; $display("FAIL %s T+2: bit_valid=%b bit_out=%b required 1 %b", name, bus.bit_valid, bus.bit_out, exp_bit);
    end
    @(negedge CLK);
    checks++;
    if (bus.bit_valid !== 1'b0) begin
      errors++; $display("FAIL %s T+3: bit_valid=%b required 0", name, bus.bit_valid);
    end
  endtask

  // from tag 7: seven alternating bits then the 8th edge; checks lock at T+2
  task automatic acquire(input string name);
    for (int k = 0; k < 7; k++) send_syms(MPB, (k % 2 == 0) ? 7 : 3);
    checks++;
    if (bus.bit_lock !== 1'b0) begin
      errors++; $display("FAIL %s early: bit_lock=%b required 0", name, bus.bit_lock);
    end
    send_sym(3);
    checks++;
    if (bus.bit_lock !== 1'b0) begin
      errors++; $display("FAIL %s T+1: bit_lock=%b required 0", name, bus.bit_lock);
    end
    @(negedge CLK);
    checks++;
    if (bus.bit_lock !== 1'b1 || bus.lock_phase !== 5'd7) begin
      errors++; $display("FAIL %s T+2: bit_lock=%b lock_phase=%0d required 1 7", name, bus.bit_lock, bus.lock_phase);
    end
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    bus.clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      bus.sample_en = i[0];
      bus.data_in   = ~i[1];
    end
    checks++;
    if ({bus.bit_out, bus.bit_valid, bus.bit_lock, bus.lock_phase} !== 8'd0) begin
      errors++; $display("FAIL reset_hold: outputs=%b required 0", {bus.bit_out, bus.bit_valid, bus.bit_lock, bus.lock_phase});
    end
    @(negedge CLK);
    bus.sample_en = 1'b0;
    RST_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); bus.sample_en = 1'b1; bus.data_in = 1'b1;
      @(negedge CLK); bus.sample_en = 1'b0;
    end
    checks++;
    if ({bus.bit_out, bus.bit_valid, bus.bit_lock, bus.lock_phase} !== 8'd0) begin
      errors++; $display("FAIL reset_release: outputs=%b required 0", {bus.bit_out, bus.bit_valid, bus.bit_lock, bus.lock_phase});
    end
    checks++;
    if (dut.samp_cnt_q !== 4'd3 || dut.ones_q !== 4'd3) begin
      errors++; $display("FAIL reset_count: samp_cnt=%0d ones=%0d required 3 3", dut.samp_cnt_q, dut.ones_q);
    end
    @(negedge CLK); bus.clear = 1'b1;
    @(negedge CLK); bus.clear = 1'b0;
    checks++;
    if (dut.samp_cnt_q !== 4'd0 || dut.ones_q !== 4'd0) begin
      errors++; $display("FAIL clear_count: samp_cnt=%0d ones=%0d required 0 0", dut.samp_cnt_q, dut.ones_q);
    end
  endtask

  task automatic test_majority();
    do_reset();
    send_sym(6);
    checks++;
    if (dut.sym_valid_q !== 1'b1 || dut.sym_q !== 1'b1) begin
      errors++; $display("FAIL vote_6: sym_valid=%b sym=%b required 1 1", dut.sym_valid_q, dut.sym_q);
    end
    send_sym(5);
    checks++;
    if (dut.sym_q !== 1'b1) begin
      errors++; $display("FAIL vote_tie: sym=%b required 1", dut.sym_q);
    end
    send_sym(4);
    checks++;
    if (dut.sym_q !== 1'b0) begin
      errors++; $display("FAIL vote_4: sym=%b required 0", dut.sym_q);
    end
  endtask

  task automatic test_lock();
    int v0;
    do_reset();
    send_syms(7, 0);
    acquire("lock");
    v0 = vcnt;
    send_syms(MPB - 1, 3);
    repeat (2) @(negedge CLK);
    checks++;
    if (vcnt !== v0) begin
      errors++; $display("FAIL partial_bit: pulses=%0d required 0", vcnt - v0);
    end
  endtask

  task automatic test_decode();
    int v0;
    v0 = vcnt;
    for (int i = 0; i < MPB - 1; i++) send_sym((i >= 5 && i <= 7) ? 3 : 7);
    finish_bit(7, 1'b1, "bit_noisy1");
    send_syms(MPB - 1, 0);
    finish_bit(0, 1'b0, "bit_clean0");
    send_syms(10, 0);
    send_syms(MPB - 11, 10);
    finish_bit(10, 1'b1, "bit_tie");
    checks++;
    if (vcnt - v0 !== 3) begin
      errors++; $display("FAIL decode_pulses: got %0d required 3", vcnt - v0);
    end
  endtask

  task automatic test_loss();
    int v0;
    send_syms(MPB - 1, 10);
    finish_bit(10, 1'b1, "bit_strong");
    v0 = vcnt;
    for (int b = 0; b < 4; b++) begin
      send_syms(10, 7);
      send_syms(9, 3);
      finish_bit(3, 1'b0, "bit_split");
      checks++;
      if (bus.bit_lock !== (b < 3)) begin
        errors++; $display("FAIL loss_lock_%0d: bit_lock=%b required %b", b, bus.bit_lock, (b < 3));
      end
    end
    checks++;
    if (bus.lock_phase !== 5'd0 || vcnt - v0 !== 4) begin
      errors++; $display("FAIL loss_state: lock_phase=%0d pulses=%0d required 0 4", bus.lock_phase, vcnt - v0);
    end
    acquire("relock");
    send_syms(MPB - 1, 3);
  endtask

  task automatic test_clear_mid_bit();
    int v0;
    send_syms(12, 7);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); bus.sample_en = 1'b1; bus.data_in = 1'b1;
    end
    @(negedge CLK); bus.clear = 1'b1;
    @(negedge CLK); bus.clear = 1'b0; bus.sample_en = 1'b0;
    checks++;
    if (bus.bit_lock !== 1'b0 || bus.bit_valid !== 1'b0 || bus.lock_phase !== 5'd0) begin
      errors++; $display("FAIL clear_outputs: lock=%b valid=%b phase=%0d required 0 0 0", bus.bit_lock, bus.bit_valid, bus.lock_phase);
    end
    checks++;
    if (dut.samp_cnt_q !== 4'd0 || dut.ones_q !== 4'd0) begin
      errors++; $display("FAIL clear_drop: samp_cnt=%0d ones=%0d required 0 0", dut.samp_cnt_q, dut.ones_q);
    end
    v0 = vcnt;
    send_syms(MPB, 7);
    repeat (2) @(negedge CLK);
    checks++;
    if (vcnt !== v0 || bus.bit_lock !== 1'b0) begin
      errors++; $display("FAIL clear_after: pulses=%0d lock=%b required 0 0", vcnt - v0, bus.bit_lock);
    end
  endtask

  task automatic test_reset_mid_bit();
    int v0;
    do_reset();
    send_syms(7, 0);
    acquire("lock2");
    send_syms(MPB - 1, 3);
    send_syms(12, 7);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); bus.sample_en = 1'b1; bus.data_in = 1'b1;
    end
    @(negedge CLK);
    #2 RST_n = 1'b0;
    #1;
    checks++;
    if ({bus.bit_out, bus.bit_valid, bus.bit_lock, bus.lock_phase} !== 8'd0) begin
      errors++; $display("FAIL rst_async: outputs=%b required 0", {bus.bit_out, bus.bit_valid, bus.bit_lock, bus.lock_phase});
    end
    @(negedge CLK);
    bus.sample_en = 1'b0;
    RST_n = 1'b1;
    v0 = vcnt;
    send_syms(MPB, 7);
    repeat (2) @(negedge CLK);
    checks++;
    if (vcnt !== v0 || bus.bit_lock !== 1'b0) begin
      errors++; $display("FAIL rst_after: pulses=%0d lock=%b required 0 0", vcnt - v0, bus.bit_lock);
    end
  endtask

  initial begin
    bus.sample_en = 1'b0;
    bus.data_in   = 1'b0;
    bus.clear     = 1'b0;
    test_reset();
    test_majority();
    test_lock();
    test_decode();
    test_loss();
    test_clear_mid_bit();
    test_reset_mid_bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
